// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Registered, parametrised ALU with a start/busy/done handshake.
//            Six single-cycle operations (ADD, SUB, AND, OR, XOR, NOT), a
//            multi-cycle unsigned shift-add multiply and a multi-cycle
//            rotate-left. Result and flags are registered and hold their
//            value until the next completion.
// Ports    : clk    - rising-edge clock
//            reset  - synchronous active-high reset (aborts any operation)
//            start  - request, sampled only while idle
//            ALUOP  - operation select, latched with start
//            A, B   - operands, latched with start
//            c_in   - carry in, latched with start
//            R      - result (low half of the product for MUL)
//            RH     - high half of the MUL product, 0 for other operations
//            zero   - result-zero flag ({RH,R} for MUL)
//            c_out  - carry / borrow-not / rotate-out / RH!=0 for MUL
//            sign   - MSB of result (MSB of RH for MUL)
//            ovf    - signed overflow for ADD/SUB, 0 otherwise
//            busy   - multi-cycle operation in progress
//            done   - one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       ALUOP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             c_in,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] RH,
    output logic             zero,
    output logic             c_out,
    output logic             sign,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    // Rotate amount needs log2(WIDTH) bits; the iteration counter needs one
    // more so that it can hold WIDTH itself for the multiply.
    localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_ROT  = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_ROL = 3'b111;

    localparam logic [CW-1:0] C_CNT_ONE = CW'(1);
    localparam logic [CW-1:0] C_CNT_MUL = CW'(WIDTH);

    // ------------------------------------------------------------------
    // State and working registers
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;      // iterations still to perform
    logic [WIDTH-1:0] r_acc;      // MUL: high accumulator
    logic [WIDTH-1:0] r_mplr;     // MUL: multiplier, fills with product low half
    logic [WIDTH-1:0] r_mcand;    // MUL: multiplicand
    logic [WIDTH-1:0] r_work;     // ROT: value being rotated

    // Architecturally visible registers
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_rh;
    logic             r_zero;
    logic             r_cout;
    logic             r_sign;
    logic             r_ovf;
    logic             r_done;

    // ------------------------------------------------------------------
    // Single-cycle datapath (operates directly on the input operands,
    // since those operations complete on the accepting edge)
    // ------------------------------------------------------------------
    logic [AW-1:0]    w_amount;
    logic [WIDTH-1:0] w_op2;
    logic [WIDTH:0]   w_sum;
    logic             w_add_ovf;
    logic [WIDTH-1:0] w_res;
    logic             w_cy;
    logic             w_ov;

    // B mod WIDTH is just the low bits because WIDTH is a power of two.
    assign w_amount = B[AW-1:0];

    // SUB is A + ~B + c_in, so the second adder operand is B or ~B.
    assign w_op2 = (ALUOP == OP_SUB) ? ~B : B;
    assign w_sum = {1'b0, A} + {1'b0, w_op2} + {{WIDTH{1'b0}}, c_in};

    // Overflow: operands agree in sign but the result does not.
    assign w_add_ovf = (A[WIDTH-1] == w_op2[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != A[WIDTH-1]);

    always_comb begin
        w_res = '0;
        w_cy  = 1'b0;
        w_ov  = 1'b0;
        case (ALUOP)
            OP_ADD,
            OP_SUB: begin
                w_res = w_sum[WIDTH-1:0];
                w_cy  = w_sum[WIDTH];
                w_ov  = w_add_ovf;
            end
            OP_AND:  w_res = A & B;
            OP_OR:   w_res = A | B;
            OP_XOR:  w_res = A ^ B;
            OP_NOT:  w_res = ~A;
            // Only reaches completion here for a zero rotate amount.
            OP_ROL:  w_res = A;
            default: w_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Multi-cycle step logic
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_acc_nx;
    logic [WIDTH-1:0] w_mplr_nx;
    logic [WIDTH-1:0] w_rot_nx;
    logic             w_last;

    // Conditionally add the multiplicand into the accumulator (with a carry
    // bit), then shift {carry, acc, multiplier} right by one. The product's
    // low half shifts into the multiplier register as its bits retire.
    assign w_mul_sum = {1'b0, r_acc} + (r_mplr[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_acc_nx  = w_mul_sum[WIDTH:1];
    assign w_mplr_nx = {w_mul_sum[0], r_mplr[WIDTH-1:1]};

    assign w_rot_nx  = {r_work[WIDTH-2:0], r_work[WIDTH-1]};

    assign w_last    = (r_cnt == C_CNT_ONE);

    // ------------------------------------------------------------------
    // Control and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mplr  <= '0;
            r_mcand <= '0;
            r_work  <= '0;
            r_r     <= '0;
            r_rh    <= '0;
            r_zero  <= 1'b0;
            r_cout  <= 1'b0;
            r_sign  <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (ALUOP == OP_MUL) begin
                            r_mcand <= A;
                            r_mplr  <= B;
                            r_acc   <= '0;
                            r_cnt   <= C_CNT_MUL;
                            r_state <= S_MUL;
                        end else if ((ALUOP == OP_ROL) && (w_amount != '0)) begin
                            r_work  <= A;
                            r_cnt   <= {1'b0, w_amount};
                            r_state <= S_ROT;
                        end else begin
                            r_r    <= w_res;
                            r_rh   <= '0;
                            r_zero <= (w_res == '0);
                            r_cout <= w_cy;
                            r_sign <= w_res[WIDTH-1];
                            r_ovf  <= w_ov;
                            r_done <= 1'b1;
                        end
                    end
                end

                S_MUL: begin
                    r_acc  <= w_acc_nx;
                    r_mplr <= w_mplr_nx;
                    r_cnt  <= r_cnt - C_CNT_ONE;
                    if (w_last) begin
                        r_r     <= w_mplr_nx;
                        r_rh    <= w_acc_nx;
                        r_zero  <= ({w_acc_nx, w_mplr_nx} == '0);
                        r_cout  <= (w_acc_nx != '0);
                        r_sign  <= w_acc_nx[WIDTH-1];
                        r_ovf   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end

                S_ROT: begin
                    r_work <= w_rot_nx;
                    r_cnt  <= r_cnt - C_CNT_ONE;
                    if (w_last) begin
                        r_r     <= w_rot_nx;
                        r_rh    <= '0;
                        r_zero  <= (w_rot_nx == '0);
                        // The bit that just wrapped into the LSB.
                        r_cout  <= w_rot_nx[0];
                        r_sign  <= w_rot_nx[WIDTH-1];
                        r_ovf   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    // busy is a pure decode of the state register; completion returns to
    // IDLE on the same edge that raises done, so the two never overlap.
    assign busy  = (r_state != S_IDLE);
    assign done  = r_done;
    assign R     = r_r;
    assign RH    = r_rh;
    assign zero  = r_zero;
    assign c_out = r_cout;
    assign sign  = r_sign;
    assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Self-checking bench for alu_seq (WIDTH=8). A stimulus process
//            issues directed and random requests; an arithmetic reference
//            model predicts each accepted request's result, flags and done
//            cycle into a queue; a monitor pops and compares on every done
//            and checks busy and output-hold every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int W = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_ROL = 3'b111;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   ALUOP;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         c_in;
    logic [W-1:0] R;
    logic [W-1:0] RH;
    logic         zero;
    logic         c_out;
    logic         sign;
    logic         ovf;
    logic         busy;
    logic         done;

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .ALUOP (ALUOP),
        .A     (A),
        .B     (B),
        .c_in  (c_in),
        .R     (R),
        .RH    (RH),
        .zero  (zero),
        .c_out (c_out),
        .sign  (sign),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Edge counter: value after the k-th rising edge is k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] r;
        logic [W-1:0] rh;
        logic         z;
        logic         c;
        logic         s;
        logic         v;
        int           done_edge;
    } exp_t;

    exp_t q[$];

    int n_chk  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    // Model of when the unit is occupied, in edge numbers.
    int free_edge = 0;   // first edge at which a start is accepted
    int busy_from = 0;   // busy expected after edges [busy_from, busy_to)
    int busy_to   = 0;

    logic [W-1:0] cur_r  = '0;
    logic [W-1:0] cur_rh = '0;
    logic         cur_z  = 1'b0;
    logic         cur_c  = 1'b0;
    logic         cur_s  = 1'b0;
    logic         cur_v  = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic longint sx(input longint x);
        return (x >= (64'sd1 <<< (W-1))) ? x - (64'sd1 <<< W) : x;
    endfunction

    // Reference model: plain integer arithmetic on the operation definitions.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic ci,
                                   output int lat);
        exp_t   e;
        longint mask = (64'sd1 <<< W) - 1;
        longint la   = longint'(a);
        longint lb   = longint'(b);
        longint lc   = longint'(ci);
        longint full;
        longint s;
        longint p;
        int     amt;
        e.r = '0; e.rh = '0; e.c = 1'b0; e.v = 1'b0; e.done_edge = 0;
        lat = 1;
        case (op)
            3'b000, 3'b001: begin
                if (op == 3'b001) lb = (~lb) & mask;
                full = la + lb + lc;
                e.r  = W'(full & mask);
                e.c  = (full >> W) != 0;
                s    = sx(la) + sx(lb) + lc;
                e.v  = (s > sx(mask >> 1)) || (s < -(mask >> 1) - 1);
            end
            3'b010: e.r = W'(la & lb);
            3'b011: e.r = W'(la | lb);
            3'b100: e.r = W'(la ^ lb);
            3'b101: e.r = W'((~la) & mask);
            3'b110: begin
                p    = la * lb;
                e.r  = W'(p & mask);
                e.rh = W'(p >> W);
                e.c  = (p >> W) != 0;
                lat  = W + 1;
            end
            default: begin
                amt = int'(lb % W);
                if (amt == 0) begin
                    e.r = a;
                end else begin
                    e.r = W'(((la << amt) | (la >> (W - amt))) & mask);
                    e.c = e.r[0];
                    lat = amt + 1;
                end
            end
        endcase
        e.z = (e.r == '0) && (e.rh == '0);
        e.s = (op == 3'b110) ? e.rh[W-1] : e.r[W-1];
        return e;
    endfunction

    // Called #1 after a rising edge; the request is seen on the next edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic ci);
        exp_t e;
        int   lat;
        int   k0;
        ALUOP = op; A = a; B = b; c_in = ci; start = 1'b1;
        k0 = cyc + 1;
        if (k0 >= free_edge) begin
            e = model(op, a, b, ci, lat);
            e.done_edge = k0 + lat - 1;
            q.push_back(e);
            busy_from = k0;
            busy_to   = k0 + lat - 1;
            free_edge = k0 + lat;
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_free();
        int g = 0;
        while ((cyc + 1 < free_edge) && (g < 100)) begin
            @(posedge clk); #1;
            g++;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, {R, RH, zero, c_out, sign, ovf, busy, done}, 0);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk("busy", busy, (cyc >= busy_from) && (cyc < busy_to));
            if (done) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done at edge %0d: got done=1 expected 0", cyc);
                end else begin
                    e = q.pop_front();
                    chk("done_edge", cyc, e.done_edge);
                    chk("R", R, e.r);
                    chk("RH", RH, e.rh);
                    chk("zero", zero, e.z);
                    chk("c_out", c_out, e.c);
                    chk("sign", sign, e.s);
                    chk("ovf", ovf, e.v);
                    cur_r = e.r; cur_rh = e.rh; cur_z = e.z;
                    cur_c = e.c; cur_s = e.s; cur_v = e.v;
                end
            end else begin
                chk("hold", {R, RH, zero, c_out, sign, ovf},
                    {cur_r, cur_rh, cur_z, cur_c, cur_s, cur_v});
            end
        end
    end

    initial begin
        logic [2:0] op;
        reset = 1'b1; start = 1'b0; ALUOP = '0; A = '0; B = '0; c_in = 1'b0;
        step(3);
        chk_all_zero("reset");
        reset = 1'b0;
        mon_en = 1'b1;

        // Directed arithmetic cases
        issue(OP_ADD, 8'hFF, 8'h01, 1'b0);
        issue(OP_ADD, 8'h7F, 8'h01, 1'b0);
        issue(OP_SUB, 8'h50, 8'h70, 1'b1);
        step(1);

        // MUL with an ignored start while busy
        wait_free();
        issue(OP_MUL, 8'hFF, 8'hFF, 1'b0);
        step(1);
        issue(OP_ADD, 8'h01, 8'h01, 1'b0);
        wait_free();
        issue(OP_MUL, 8'h00, 8'h37, 1'b0);
        wait_free();
        issue(OP_ROL, 8'h81, 8'h03, 1'b0);
        wait_free();
        issue(OP_ROL, 8'h81, 8'h08, 1'b0);
        wait_free();

        // Reset three cycles into a multiply
        issue(OP_MUL, 8'h5A, 8'hC3, 1'b0);
        step(2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        q.delete();
        free_edge = 0; busy_from = 0; busy_to = 0;
        cur_r = '0; cur_rh = '0; cur_z = 1'b0; cur_c = 1'b0; cur_s = 1'b0; cur_v = 1'b0;
        chk_all_zero("midop_reset");
        issue(OP_ADD, 8'h02, 8'h03, 1'b0);

        // Random traffic; some requests land while busy and must be dropped
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) != 0) wait_free();
            op = 3'($urandom_range(7));
            issue(op, W'($urandom), W'($urandom), 1'($urandom_range(1)));
            step($urandom_range(1));
        end

        begin
            int g = 0;
            while ((q.size() != 0) && (g < 50)) begin
                @(posedge clk); #1;
                g++;
            end
        end
        chk("drain_empty", q.size(), 0);
        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor of the 4-bit combinational ALU.
- Supports WIDTH-bit operands and eight operations, including a multi-cycle unsigned shift-add multiply and a multi-cycle rotate.
- Operands and operation are latched on a start/busy/done handshake; result and flags are registered and hold until the next completion.
- Sits between the datapath register file and the control unit, which sequences it.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥2 and a power of 2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- ALUOP  input  3  operation select, latched with start
- A  input  WIDTH  operand A, latched with start
- B  input  WIDTH  operand B, latched with start
- c_in  input  1  carry in, latched with start
- R  output  WIDTH  result (low half for MUL)
- RH  output  WIDTH  high half of MUL product; 0 for all other ops
- zero  output  1  result-zero flag
- c_out  output  1  carry/borrow-not/rotate-out flag
- sign  output  1  MSB of result
- ovf  output  1  signed overflow flag
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (synchronous, active-high; also overrides mid-operation): state=IDLE; R, RH, zero, c_out, sign, ovf, busy, done all 0. The in-flight operation is discarded and no done is issued.
- ALUOP encoding:
  - 000 ADD: A+B+c_in
  - 001 SUB: A+~B+c_in (c_in=1 gives A-B)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 NOT: ~A
  - 110 MUL: unsigned A*B, 2·WIDTH-bit product
  - 111 ROL: rotate A left by B mod WIDTH
- States: IDLE, MUL, ROT.
- IDLE:
  - start=1 with ALUOP in 000..101: compute and register R and flags on that same edge, pulse done next cycle, remain in IDLE. Latency 1 edge.
  - start=1 with ALUOP=110: latch operands, clear accumulator, counter=WIDTH, go to MUL.
  - start=1 with ALUOP=111: latch A and amount=B mod WIDTH. If amount=0, complete as a single-cycle op (R=A, c_out=0). Otherwise go to ROT.
- MUL: one iteration per cycle. If multiplier LSB=1, add multiplicand into the high accumulator (WIDTH+1 bits incl. carry). Then shift {carry,acc,multiplier} right one bit. After WIDTH iterations, write RH/R, pulse done, return to IDLE. done occurs WIDTH+1 edges after the start edge.
- ROT: one bit per cycle, R ← {R[WIDTH-2:0], R[WIDTH-1]}. After n steps, done occurs n+1 edges after the start edge.
- busy: 1 in MUL/ROT, 0 in IDLE. Never high in the same cycle as done.
- done: exactly one cycle wide per accepted start.
- start while busy: ignored, no queuing.
- start in the cycle done is high: accepted (state is IDLE).
- Flags are updated only when done is raised; they hold otherwise.
  - zero: R==0, and for MUL the full {RH,R}==0.
  - sign: R[WIDTH-1]; for MUL, RH[WIDTH-1].
  - c_out:
    - ADD/SUB: carry out of bit WIDTH-1.
    - MUL: RH!=0.
    - ROL: last bit rotated into the LSB (0 if amount=0).
    - Logic ops: 0.
  - ovf: for ADD/SUB, (OP1[MSB]==OP2[MSB]) && (R[MSB]!=OP1[MSB]), where OP2 is B or ~B; 0 for other ops.
  - RH: written to 0 on every non-MUL completion.
- All arithmetic is modulo 2^WIDTH except the MUL product (2·WIDTH bits).

Test Plan (WIDTH=8):
- ADD A=0xFF, B=0x01, c_in=0 -> next cycle done=1, R=0x00, zero=1, c_out=1, ovf=0, sign=0, busy never 1.
- ADD A=0x7F, B=0x01, c_in=0 -> R=0x80, ovf=1, sign=1, c_out=0. SUB A=0x50, B=0x70, c_in=1 -> R=0xE0, c_out=0, sign=1, ovf=0.
- MUL A=0xFF, B=0xFF -> busy for 8 cycles, done 9 edges after start, RH=0xFE, R=0x01, c_out=1, sign=1, zero=0. MUL A=0x00, B=0x37 -> RH=0, R=0, zero=1.
- ROL A=0x81, B=0x03 -> done 4 edges after start, R=0x0C, c_out=0. ROL A=0x81, B=0x08 (amount 0) -> done after 1 edge, R=0x81, c_out=0.
- During MUL busy, pulse start with ADD A=1, B=1 -> ignored; MUL result unchanged; exactly one done. Back-to-back start in the done cycle -> accepted.
- Assert reset 3 cycles into MUL -> next edge all outputs 0, state IDLE, no done. A following ADD 0x02+0x03 -> R=0x05, done after 1 edge.
